wb_charlieplex: RTL and testbench

Parametrised Wishbone B4 pipelined charlieplexed LED matrix driver: a double-buffered frame store of ROWS words × COLS bits, a per-pixel time-multiplexed scan over PINS tri-state pins, global 8-bit PWM brightness, and frame-synchronous buffer swap. It sits on the system Wishbone bus as a peripheral and drives the LED pins directly through top-level tri-state buffers. With defaults it drives the 7×5 charlieplexed display.

---
 rtl/wb_charlie_pkg.sv | 9 +
 rtl/charlie_scan.sv | 38 +++
 rtl/wb_charlieplex.sv | 107 ++++++++++
 tb/tb_wb_charlieplex.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_charlie_pkg.sv
// wb_charlie_pkg: register addresses, CTRL bit positions and reset values for wb_charlieplex.
package wb_charlie_pkg;
    localparam logic [3:0] ADDR_CTRL   = 4'hC;
    localparam logic [3:0] ADDR_BRIGHT = 4'hD;
    localparam logic [3:0] ADDR_STATUS = 4'hE;
    localparam int         CTRL_EN     = 0;
    localparam int         CTRL_SWAP   = 1;
    localparam logic [7:0] BRIGHT_RST  = 8'hFF;
endpackage

// File: rtl/charlie_scan.sv
// charlie_scan: slot counter and (row, col) pixel cursor with a frame-end pulse.
module charlie_scan #(
    parameter  int PINS      = 7,
    parameter  int ROWS      = 5,
    parameter  int SLOT_LOG2 = 9,
    localparam int CW        = $clog2(PINS)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    output logic [CW-1:0] o_row,
    output logic [CW-1:0] o_col,
    output logic [7:0]    o_phase,
    output logic          o_frame_end
);
    logic [SLOT_LOG2-1:0] r_cnt;
    logic [CW-1:0]        r_row, r_col;
    logic                 w_slot_end, w_last_row;
    assign w_slot_end = &r_cnt;
    assign w_last_row = r_row == CW'(ROWS - 1);
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
            r_row <= '0;
            r_col <= '0;
        end else begin
            r_cnt <= r_cnt + SLOT_LOG2'(1);
            if (w_slot_end) begin
                r_row <= w_last_row ? '0 : r_row + CW'(1);
                if (w_last_row) r_col <= (r_col == CW'(PINS - 1)) ? '0 : r_col + CW'(1);
            end
        end
    end
    assign o_row       = r_row;
    assign o_col       = r_col;
    // PWM phase is the top byte of the slot counter, so duty resolution is independent of slot length.
    assign o_phase     = r_cnt[SLOT_LOG2-1 -: 8];
    assign o_frame_end = w_slot_end && w_last_row && r_col == CW'(PINS - 1);
endmodule

// File: rtl/wb_charlieplex.sv
// wb_charlieplex: Wishbone B4 pipelined charlieplexed LED matrix driver with double-buffered frame store
// and global PWM brightness; FRONT is refreshed from BACK only at frame end when a swap is pending.
module wb_charlieplex
    import wb_charlie_pkg::*;
#(
    parameter int WB_CLK_HZ = 48_000_000,
    parameter int PINS      = 7,
    parameter int ROWS      = 5,
    parameter int SLOT_LOG2 = 9
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_ni,
    input  logic            wb_cyc_i,
    input  logic            wb_stb_i,
    input  logic            wb_we_i,
    input  logic [3:0]      wb_adr_i,
    input  logic [31:0]     wb_dat_i,
    output logic [31:0]     wb_dat_o,
    output logic            wb_stall_o,
    output logic            wb_ack_o,
    output logic [PINS-1:0] charlie_o,
    output logic [PINS-1:0] charlie_oe
);
    localparam int CW = $clog2(PINS);

    if (SLOT_LOG2 < 8 || ROWS < 1 || ROWS > PINS - 1 || ROWS > 12 || WB_CLK_HZ <= 0) begin : g_bad_params
        $error("wb_charlieplex: illegal parameter set");
    end

    logic [PINS-1:0] r_back  [ROWS];
    logic [PINS-1:0] r_front [ROWS];
    logic            r_en, r_pend, r_ack;
    logic [7:0]      r_bright;
    logic [15:0]     r_frames;
    logic [31:0]     r_dat, w_rd;
    logic [PINS-1:0] r_o, r_oe, w_front_row, w_row_bit, w_col_bit;
    logic [CW-1:0]   w_row, w_col, w_row_pin;
    logic [7:0]      w_phase;
    logic            w_frame_end, w_req, w_wr, w_lit, w_unused;

    assign w_req    = wb_cyc_i & wb_stb_i;
    assign w_wr     = w_req & wb_we_i;
    assign w_unused = ^wb_dat_i[31:8];

    charlie_scan #(.PINS(PINS), .ROWS(ROWS), .SLOT_LOG2(SLOT_LOG2)) u_scan (
        .i_clk       (wb_clk_i),
        .i_rst_n     (wb_rst_ni),
        .o_row       (w_row),
        .o_col       (w_col),
        .o_phase     (w_phase),
        .o_frame_end (w_frame_end)
    );

    always_comb begin
        w_rd        = '0;
        w_front_row = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (wb_adr_i == 4'(r)) w_rd = 32'(r_back[r]);
            if (w_row == CW'(r)) w_front_row = r_front[r];
        end
        w_rd = (wb_adr_i == ADDR_CTRL)   ? (32'(r_pend) << CTRL_SWAP) | (32'(r_en) << CTRL_EN) :
               (wb_adr_i == ADDR_BRIGHT) ? 32'(r_bright) :
               (wb_adr_i == ADDR_STATUS) ? 32'(r_frames) : w_rd;
    end

    // The diagonal pixel (row == col) borrows the next pin up, so row_pin skips the column pin.
    assign w_row_pin = (w_row < w_col) ? w_row : w_row + CW'(1);
    assign w_row_bit = PINS'(1) << w_row_pin;
    assign w_col_bit = PINS'(1) << w_col;
    assign w_lit     = r_en && w_front_row[w_col] && (w_phase < r_bright);

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_ack    <= 1'b0;
            r_dat    <= '0;
            r_en     <= 1'b0;
            r_pend   <= 1'b0;
            r_bright <= BRIGHT_RST;
            r_frames <= '0;
            r_o      <= '0;
            r_oe     <= '0;
            for (int r = 0; r < ROWS; r++) begin
                r_back[r]  <= '0;
                r_front[r] <= '0;
            end
        end else begin
            r_ack  <= w_req;
            r_dat  <= w_req ? w_rd : '0;
            r_o    <= w_lit ? w_row_bit : '0;
            r_oe   <= w_lit ? (w_row_bit | w_col_bit) : '0;
            r_pend <= (r_pend && !w_frame_end) || (w_wr && wb_adr_i == ADDR_CTRL && wb_dat_i[CTRL_SWAP]);
            if (w_frame_end) r_frames <= r_frames + 16'd1;
            for (int r = 0; r < ROWS; r++) begin
                if (w_frame_end && r_pend) r_front[r] <= r_back[r];
                if (w_wr && wb_adr_i == 4'(r)) r_back[r] <= wb_dat_i[PINS-1:0];
            end
            if (w_wr && wb_adr_i == ADDR_CTRL) r_en <= wb_dat_i[CTRL_EN];
            if (w_wr && wb_adr_i == ADDR_BRIGHT) r_bright <= wb_dat_i[7:0];
        end
    end

    assign wb_ack_o   = r_ack;
    assign wb_dat_o   = r_dat;
    assign wb_stall_o = 1'b0;
    assign charlie_o  = r_o;
    assign charlie_oe = r_oe;
endmodule

// File: tb/tb_wb_charlieplex.sv
// tb_wb_charlieplex: directed plus random bus traffic against a time-indexed behavioural model of the driver.
module tb_wb_charlieplex;
    localparam int PINS  = 4;
    localparam int ROWS  = 3;
    localparam int S     = 8;
    localparam int SLOT  = 1 << S;
    localparam int FRAME = SLOT * ROWS * PINS;

    logic            clk = 0, rst_n = 1, cyc = 0, stb = 0, we = 0, chk = 0;
    logic [3:0]      adr = 0;
    logic [31:0]     dat = 0, dat_o;
    logic            stall, ack;
    logic [PINS-1:0] po, poe;
    int              n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    wb_charlieplex #(.PINS(PINS), .ROWS(ROWS), .SLOT_LOG2(S)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
        .wb_adr_i(adr), .wb_dat_i(dat), .wb_dat_o(dat_o), .wb_stall_o(stall), .wb_ack_o(ack),
        .charlie_o(po), .charlie_oe(poe)
    );

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40) $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Model state: t counts cycles since reset release; cursor and frame end follow from t by arithmetic.
    logic [PINS-1:0] m_back [ROWS], m_front [ROWS];
    logic            m_en, m_pend, e_ack;
    logic [7:0]      m_bright;
    int              m_frames, m_t, d_row, d_col, d_cnt;
    logic [31:0]     e_dat;
    logic [PINS-1:0] e_o, e_oe;

    function automatic logic [31:0] m_read(logic [3:0] a);
        if (int'(a) < ROWS) return 32'(m_back[int'(a)]);
        case (a)
            4'hC:    return {30'd0, m_pend, m_en};
            4'hD:    return {24'd0, m_bright};
            4'hE:    return 32'(m_frames % 65536);
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int  cnt, slot, row, col, rp;
        bit  fe, lit;
        if (!rst_n) begin
            for (int r = 0; r < ROWS; r++) begin m_back[r] = '0; m_front[r] = '0; end
            m_en = 0; m_pend = 0; m_bright = 8'hFF; m_frames = 0; m_t = 0;
            e_ack = 0; e_dat = 0; e_o = 0; e_oe = 0; d_row = 0; d_col = 0; d_cnt = 0;
        end else begin
            cnt  = m_t % SLOT;
            slot = m_t / SLOT;
            row  = slot % ROWS;
            col  = (slot / ROWS) % PINS;
            fe   = (m_t % FRAME) == FRAME - 1;
            lit  = m_en && m_front[row][col] && ((cnt >> (S - 8)) < int'(m_bright));
            rp   = (row < col) ? row : row + 1;
            e_o  = lit ? PINS'(1 << rp) : '0;
            e_oe = lit ? PINS'((1 << rp) | (1 << col)) : '0;
            d_row = row; d_col = col; d_cnt = cnt;
            e_ack = cyc && stb;
            e_dat = e_ack ? m_read(adr) : 32'd0;
            if (fe) begin
                if (m_pend) for (int r = 0; r < ROWS; r++) m_front[r] = m_back[r];
                m_pend = 0;
                m_frames++;
            end
            if (e_ack && we) begin
                if (int'(adr) < ROWS) m_back[int'(adr)] = dat[PINS-1:0];
                else if (adr == 4'hC) begin m_en = dat[0]; if (dat[1]) m_pend = 1; end
                else if (adr == 4'hD) m_bright = dat[7:0];
            end
            m_t++;
        end
    end

    always @(negedge clk) begin
        if (chk) begin
            check("ack", 32'(ack), 32'(e_ack));
            check("dat_o", dat_o, e_dat);
            check("charlie_o", 32'(po), 32'(e_o));
            check("charlie_oe", 32'(poe), 32'(e_oe));
            check("stall", 32'(stall), 32'(1'b0));
        end
    end

    task automatic wb_wr(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk); cyc = 1; stb = 1; we = 1; adr = a; dat = d;
        @(negedge clk); cyc = 0; stb = 0; we = 0;
    endtask

    task automatic wb_rd(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk); cyc = 1; stb = 1; we = 0; adr = a;
        @(negedge clk); d = dat_o; cyc = 0; stb = 0;
    endtask

    task automatic rd_chk(input string name, input logic [3:0] a, input logic [31:0] exp);
        logic [31:0] v;
        wb_rd(a, v);
        check(name, v, exp);
    endtask

    task automatic timeout(input string name);
        n_cmp++; n_bad++;
        $display("FAIL %s: wait expired, expected event within %0d cycles", name, 3 * FRAME);
    endtask

    // Returns at the negedge where the pins show slot (r, c) at slot counter k.
    task automatic wait_disp(input int r, input int c, input int k);
        int n = 0;
        do begin @(negedge clk); n++; end
        while (!(d_row == r && d_col == c && d_cnt == k) && n < 3 * FRAME);
        if (n >= 3 * FRAME) timeout("wait_disp");
    endtask

    // Returns at the negedge inside the cycle whose index within the frame is k.
    task automatic wait_mod(input int k);
        int n = 0;
        do begin @(negedge clk); n++; end
        while ((m_t % FRAME) != k && n < 3 * FRAME);
        if (n >= 3 * FRAME) timeout("wait_mod");
    endtask

    task automatic count_on(input string name, input int exp);
        int on = 0;
        wait_disp(0, 0, 0);
        for (int i = 0; i < SLOT; i++) begin
            if (i > 0) @(negedge clk);
            if (poe != 0) on++;
        end
        check(name, 32'(on), 32'(exp));
    endtask

    initial begin
        logic [31:0] s0;
        #1 rst_n = 0; chk = 1;
        repeat (3) @(negedge clk);
        rst_n = 1;
        rd_chk("ctrl_reset", 4'hC, 32'h0);
        rd_chk("bright_reset", 4'hD, 32'hFF);
        rd_chk("status_reset", 4'hE, 32'h0);
        rd_chk("unmapped_read", 4'h7, 32'h0);

        wb_wr(4'h0, 32'h1);
        wb_wr(4'hC, 32'h3);
        rd_chk("swap_pending", 4'hC, 32'h3);
        wait_mod(1);
        rd_chk("swap_cleared", 4'hC, 32'h1);
        wait_disp(0, 0, 100);
        check("px00_oe", 32'(poe), 32'h3);
        check("px00_o", 32'(po), 32'h2);

        wb_wr(4'h2, 32'h7F);
        wait_disp(2, 3, 100);
        check("no_swap_dark", 32'(poe), 32'h0);
        wb_wr(4'hC, 32'h3);
        wait_disp(2, 3, 100);
        check("px23_oe", 32'(poe), 32'hC);
        check("px23_o", 32'(po), 32'h4);

        wb_wr(4'hD, 32'h40);
        count_on("pwm_0x40_on", 64);
        wb_wr(4'hD, 32'h0);
        count_on("pwm_0_on", 0);
        wb_wr(4'hD, 32'hFF);

        wb_wr(4'h1, 32'h5);
        wb_rd(4'hE, s0);
        wait_mod(FRAME - 1);
        cyc = 1; stb = 1; we = 1; adr = 4'hC; dat = 32'h3;
        @(negedge clk); cyc = 0; stb = 0; we = 0;
        rd_chk("fe_swap_pending", 4'hC, 32'h3);
        wait_disp(1, 0, 100);
        check("fe_swap_no_copy", 32'(poe), 32'h0);
        wait_disp(1, 0, 100);
        check("fe_swap_late_oe", 32'(poe), 32'h5);
        check("fe_swap_late_o", 32'(po), 32'h4);
        rd_chk("status_plus2", 4'hE, (s0 + 32'd2) & 32'hFFFF);
        rd_chk("fe_swap_done", 4'hC, 32'h1);

        wait_disp(1, 0, 50);
        check("pre_reset_lit", 32'(poe), 32'h5);
        @(posedge clk); #3 rst_n = 0;
        #1;
        check("async_rst_oe", 32'(poe), 32'h0);
        check("async_rst_o", 32'(po), 32'h0);
        check("async_rst_dat", dat_o, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        rd_chk("back1_after_rst", 4'h1, 32'h0);
        rd_chk("ctrl_after_rst", 4'hC, 32'h0);
        wb_wr(4'h0, 32'h1);
        wb_wr(4'hC, 32'h3);
        wait_disp(0, 0, 100);
        check("front_after_rst", 32'(poe), 32'h0);
        wait_disp(0, 0, 100);
        check("restart_px00_oe", 32'(poe), 32'h3);

        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            cyc = ($urandom % 4) != 0;
            stb = $urandom % 2;
            we  = $urandom % 2;
            adr = 4'($urandom);
            dat = $urandom;
        end
        @(negedge clk); cyc = 0; stb = 0; we = 0;
        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #(2_000_000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
